term_dma_writer: RTL and testbench
==================================

TERM_DMA_WRITER -- requirements
Module: term_dma_writer

Interface
REQ-001 The block SHALL have a single clock domain i_clk; reset i_rst SHALL be synchronous and active-high.
REQ-002 Parameter COLS, default 80, SHALL set text columns per row.
REQ-003 Parameter ROWS, default 25, SHALL set text rows.
REQ-004 Parameter BLANK, default 8'h20, SHALL set the character code written when clearing cells.
REQ-005 Ports SHALL be:
- i_clk  in  1  system clock (pixel clock domain)
- i_rst  in  1  synchronous active-high reset
- i_data  in  8  byte from host stream
- i_valid  in  1  i_data valid
- o_ready  out  1  byte accepted when i_valid & o_ready
- o_vram_addr  out  12  video RAM write address (row*COLS+col)
- o_vram_data  out  8  video RAM write data
- o_vram_we  out  1  one-cycle write strobe
- o_cursor_addr  out  12  cursor cell address to display stage
- o_cursor_on  out  1  cursor display enable
- o_busy  out  1  clear operation in progress

Function
REQ-006 The FSM SHALL have states INIT_CLR, IDLE, CLR_LINE and CLR_SCR; o_ready SHALL be 1 only in IDLE.
REQ-007 All outputs SHALL be registered; a write for an accepted byte SHALL appear with o_vram_we=1 in the cycle after acceptance (latency 1).
REQ-008 In IDLE the block SHALL accept one byte per cycle back-to-back while no clear is triggered.
REQ-009 Printable byte (8'h20..8'h7E): write byte at cursor, then advance col by 1.
REQ-010 Advance from col COLS-1 SHALL move to col 0 of the next row; from row ROWS-1 the next row SHALL be row 0 (wrap, no scroll).
REQ-011 Entering a new row via advance or LF SHALL go to CLR_LINE, writing BLANK to the COLS cells of the new row in ascending address order, one per cycle, then return to IDLE.
REQ-012 CR (8'h0D): col=0, no write.
REQ-013 LF (8'h0A): col=0, row=next row (with wrap), then CLR_LINE.
REQ-014 BS (8'h08): cursor back one cell, no write; at col 0 move to col COLS-1 of previous row; at address 0 no change.
REQ-015 FF (8'h0C): CLR_SCR writing BLANK to addresses 0..COLS*ROWS-1 ascending, then cursor=0, IDLE.
REQ-016 All other bytes SHALL be consumed with no write and no cursor change.
REQ-017 o_cursor_addr SHALL always equal row*COLS+col, maintained incrementally (no multiplier), and update in the same cycle as the triggering write.
REQ-018 o_cursor_on SHALL be 0 in INIT_CLR and CLR_SCR, 1 otherwise; o_busy SHALL be 1 in INIT_CLR, CLR_LINE and CLR_SCR.
REQ-019 o_vram_we SHALL never be asserted with an address >= COLS*ROWS.

Reset
REQ-020 On i_rst: state=INIT_CLR, clear counter=0, cursor=0, o_vram_we=0, o_ready=0, o_cursor_on=0, o_busy=1, o_vram_addr=0, o_vram_data=BLANK.
REQ-021 INIT_CLR SHALL behave as CLR_SCR (first write the cycle after reset deasserts) and then enter IDLE.
REQ-022 Reset asserted mid-clear or mid-stream SHALL abort immediately and restart INIT_CLR from address 0; an in-flight byte SHALL be dropped.

Structure
REQ-023 A shared package term_pkg SHALL hold COLS, ROWS, CELLS (=2000), BLANK, control codes CR/LF/BS/FF and the FSM state enum.
REQ-024 Row/col/address tracking (advance, back, newline, wrap) SHALL be one sub-module term_cursor; the FSM and clear counter SHALL be in term_dma_writer.

Verification
REQ-025 Reset release -> 2000 writes of 8'h20 at addresses 0..1999, then o_ready=1, o_cursor_addr=0, o_cursor_on=1, o_busy=0.
REQ-026 Send 'A' (8'h41) in IDLE -> next cycle we=1, addr=0, data=8'h41, o_cursor_addr=1.
REQ-027 Send 80 printables back-to-back -> last written at addr 79, then 80 BLANK writes at 80..159 with o_ready=0, cursor=80.
REQ-028 Cursor at row 24 col 5, send LF -> BLANK writes at 0..79, cursor=0; then BS -> no write, cursor stays 0.
REQ-029 Cursor=80, send BS -> cursor=79, no write; send CR -> cursor=0; send 8'h07 -> no write, cursor unchanged.
REQ-030 Send FF, assert i_rst after 500 clear writes -> clearing restarts at address 0, completes 2000 writes, cursor=0.

Source files
------------

// File: rtl/term_pkg.sv
// Shared constants, control codes and state/operation enums for the
// terminal-to-video-RAM writer.
`timescale 1ns/1ps
package term_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    CLR_LINE,
    CLR_SCR
  } state_t;

  // Cursor movement requests issued by the writer FSM to the cursor tracker.
  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_BACK,
    CUR_CR,
    CUR_NL,
    CUR_HOME
  } cur_op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/term_cursor.sv
// Row/column/linear-address cursor tracker. The linear address is kept
// incrementally alongside row and col so no multiplier is needed.
`timescale 1ns/1ps
module term_cursor #(
  parameter int COLS = term_pkg::COLS,
  parameter int ROWS = term_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op,
  output logic [11:0] addr,
  output logic        at_last_col,
  output logic [11:0] next_row_base
);
  import term_pkg::*;

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [11:0]      ROW_STEP = 12'(COLS);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             at_last_row;
  cur_op_t          op_e;

  assign op_e        = cur_op_t'(op);
  assign at_last_col = (col == LAST_COL);
  assign at_last_row = (row == LAST_ROW);
  // Start address of the row below, wrapping the bottom row back to the top.
  assign next_row_base = at_last_row ? 12'd0 : (addr - 12'(col) + ROW_STEP);

  // Apply one cursor movement per cycle; address tracks row/col in lockstep.
  always_ff @(posedge clk) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else begin
      case (op_e)
        CUR_ADV: begin
          if (at_last_col) begin
            col  <= '0;
            row  <= at_last_row ? '0 : row + 1'b1;
            addr <= next_row_base;
          end else begin
            col  <= col + 1'b1;
            addr <= addr + 1'b1;
          end
        end
        CUR_BACK: begin
          // Home cell is a hard stop; otherwise step back, crossing rows.
          if (addr != 12'd0) begin
            if (col == '0) begin
              col <= LAST_COL;
              row <= row - 1'b1;
            end else begin
              col <= col - 1'b1;
            end
            addr <= addr - 1'b1;
          end
        end
        CUR_CR: begin
          col  <= '0;
          addr <= addr - 12'(col);
        end
        CUR_NL: begin
          col  <= '0;
          row  <= at_last_row ? '0 : row + 1'b1;
          addr <= next_row_base;
        end
        CUR_HOME: begin
          row  <= '0;
          col  <= '0;
          addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/term_dma_writer.sv
// Host byte stream to text video RAM writer: prints characters, handles
// CR/LF/BS/FF, and clears lines or the whole screen one cell per cycle.
`timescale 1ns/1ps
module term_dma_writer #(
  parameter int         COLS  = term_pkg::COLS,
  parameter int         ROWS  = term_pkg::ROWS,
  parameter logic [7:0] BLANK = term_pkg::BLANK
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [11:0] o_vram_addr,
  output logic [7:0]  o_vram_data,
  output logic        o_vram_we,
  output logic [11:0] o_cursor_addr,
  output logic        o_cursor_on,
  output logic        o_busy
);
  import term_pkg::*;

  localparam int          NUM_CELLS    = COLS * ROWS;
  localparam logic [11:0] LAST_CELL    = 12'(NUM_CELLS - 1);
  localparam logic [11:0] ROW_LAST_OFS = 12'(COLS - 1);

  state_t      state;
  logic [11:0] clr_addr;
  logic [11:0] clr_last;
  logic        clr_done;
  logic        accept;
  logic        printable;
  logic        start_line;
  logic        start_scr;
  cur_op_t     cur_op;
  logic [11:0] cur_addr;
  logic [11:0] next_row_base;
  logic        at_last_col;

  assign accept    = o_ready & i_valid;
  assign printable = is_printable(i_data);
  assign clr_done  = (clr_addr == clr_last);

  term_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk           (i_clk),
    .rst           (i_rst),
    .op            (cur_op),
    .addr          (cur_addr),
    .at_last_col   (at_last_col),
    .next_row_base (next_row_base)
  );

  assign o_cursor_addr = cur_addr;

  // Decode the accepted byte into a cursor move and any clear it triggers.
  always_comb begin
    cur_op     = CUR_NONE;
    start_line = 1'b0;
    start_scr  = 1'b0;
    if (accept) begin
      if (printable) begin
        cur_op     = CUR_ADV;
        start_line = at_last_col;
      end else begin
        case (i_data)
          CR: cur_op = CUR_CR;
          LF: begin
            cur_op     = CUR_NL;
            start_line = 1'b1;
          end
          BS: cur_op = CUR_BACK;
          FF: start_scr = 1'b1;
          default: ;
        endcase
      end
    end else if ((state == INIT_CLR || state == CLR_SCR) && clr_done) begin
      // Full-screen clears park the cursor at home as they finish.
      cur_op = CUR_HOME;
    end
  end

  // Writer FSM: byte writes in IDLE, one blank cell per cycle while clearing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= INIT_CLR;
      clr_addr    <= '0;
      clr_last    <= LAST_CELL;
      o_vram_we   <= 1'b0;
      o_vram_addr <= '0;
      o_vram_data <= BLANK;
      o_ready     <= 1'b0;
      o_cursor_on <= 1'b0;
      o_busy      <= 1'b1;
    end else begin
      o_vram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && printable) begin
            o_vram_we   <= 1'b1;
            o_vram_addr <= cur_addr;
            o_vram_data <= i_data;
          end
          if (start_line) begin
            // The new row's base is where the cursor lands this same edge.
            state    <= CLR_LINE;
            clr_addr <= next_row_base;
            clr_last <= next_row_base + ROW_LAST_OFS;
            o_ready  <= 1'b0;
            o_busy   <= 1'b1;
          end else if (start_scr) begin
            state       <= CLR_SCR;
            clr_addr    <= '0;
            clr_last    <= LAST_CELL;
            o_ready     <= 1'b0;
            o_busy      <= 1'b1;
            o_cursor_on <= 1'b0;
          end
        end
        default: begin
          o_vram_we   <= 1'b1;
          o_vram_addr <= clr_addr;
          o_vram_data <= BLANK;
          clr_addr    <= clr_addr + 1'b1;
          if (clr_done) begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_busy      <= 1'b0;
            o_cursor_on <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_dma_writer.sv
// Bench for term_dma_writer: a table of single-byte vectors plus hand-built
// sequences for clears, wrap and reset abort; VRAM writes are checked
// against a queue of expected writes.
`timescale 1ns/1ps
module tb_term_dma_writer;

  localparam int NCOLS  = 80;
  localparam int NCELLS = 2000;

  logic        clk;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] o_vram_addr;
  logic [7:0]  o_vram_data;
  logic        o_vram_we;
  logic [11:0] o_cursor_addr;
  logic        o_cursor_on;
  logic        o_busy;

  term_dma_writer dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_vram_addr   (o_vram_addr),
    .o_vram_data   (o_vram_data),
    .o_vram_we     (o_vram_we),
    .o_cursor_addr (o_cursor_addr),
    .o_cursor_on   (o_cursor_on),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0]  b;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
    logic [11:0] cur;
  } vec_t;

  wr_t  q[$];
  wr_t  exp_w;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[11];
  vec_t v;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_vram_we === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required no write", o_vram_addr, o_vram_data);
      end else begin
        exp_w = q.pop_front();
        if (o_vram_addr !== exp_w.addr || o_vram_data !== exp_w.data) begin
          n_fail++;
          $display("FAIL vram_write: got addr %0d data %0h, required addr %0d data %0h",
                   o_vram_addr, o_vram_data, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) q.push_back('{addr: 12'(base + i), data: 8'h20});
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  task automatic apply(input vec_t vv, input string name);
    wait_idle(3000, name);
    if (vv.we) q.push_back('{addr: vv.addr, data: vv.data});
    i_data  = vv.b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check({name, "_we"}, 32'(o_vram_we), 32'(vv.we));
    check({name, "_cursor"}, 32'(o_cursor_addr), 32'(vv.cur));
  endtask

  task automatic goto_last_row();
    for (int r = 1; r < 25; r++) begin
      wait_idle(200, "lf_walk");
      push_clear(r * NCOLS, NCOLS);
      i_data  = 8'h0A;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      check("lf_walk_cursor", 32'(o_cursor_addr), 32'(r * NCOLS));
      check("lf_walk_busy", 32'(o_busy), 32'd1);
      check("lf_walk_cursor_on", 32'(o_cursor_on), 32'd1);
    end
    wait_idle(200, "lf_walk_end");
  endtask

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 12'd0, 8'h41, 12'd1};
    vecs[1]  = '{8'h42, 1'b1, 12'd1, 8'h42, 12'd2};
    vecs[2]  = '{8'h07, 1'b0, 12'd0, 8'h00, 12'd2};
    vecs[3]  = '{8'h08, 1'b0, 12'd0, 8'h00, 12'd1};
    vecs[4]  = '{8'h0D, 1'b0, 12'd0, 8'h00, 12'd0};
    vecs[5]  = '{8'h08, 1'b0, 12'd0, 8'h00, 12'd0};
    vecs[6]  = '{8'h7E, 1'b1, 12'd0, 8'h7E, 12'd1};
    vecs[7]  = '{8'h7F, 1'b0, 12'd0, 8'h00, 12'd1};
    vecs[8]  = '{8'h1F, 1'b0, 12'd0, 8'h00, 12'd1};
    vecs[9]  = '{8'h20, 1'b1, 12'd1, 8'h20, 12'd2};
    vecs[10] = '{8'h80, 1'b0, 12'd0, 8'h00, 12'd2};

    // Reset state and power-up screen clear.
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) tick();
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_cursor_on", 32'(o_cursor_on), 32'd0);
    check("rst_we", 32'(o_vram_we), 32'd0);
    check("rst_addr", 32'(o_vram_addr), 32'd0);
    check("rst_data", 32'(o_vram_data), 32'h20);
    check("rst_cursor", 32'(o_cursor_addr), 32'd0);
    push_clear(0, NCELLS);
    i_rst = 1'b0;
    tick();
    check("init_first_we", 32'(o_vram_we), 32'd1);
    wait_idle(2100, "init");
    check("init_cursor", 32'(o_cursor_addr), 32'd0);
    check("init_cursor_on", 32'(o_cursor_on), 32'd1);
    check("init_busy", 32'(o_busy), 32'd0);
    check("init_all_writes", 32'(q.size()), 32'd0);

    // Single-byte vectors from the home cell.
    for (int i = 0; i < 11; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Form feed: full clear, then cursor home.
    wait_idle(10, "ff");
    push_clear(0, NCELLS);
    i_data  = 8'h0C;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("ff_cursor_on", 32'(o_cursor_on), 32'd0);
    check("ff_busy", 32'(o_busy), 32'd1);
    check("ff_ready", 32'(o_ready), 32'd0);
    wait_idle(2100, "ff_done");
    check("ff_cursor", 32'(o_cursor_addr), 32'd0);
    check("ff_all_writes", 32'(q.size()), 32'd0);

    // 80 printables back-to-back, then automatic clear of row 1.
    for (int k = 0; k < NCOLS; k++) q.push_back('{addr: 12'(k), data: 8'(8'h30 + k % 10)});
    push_clear(NCOLS, NCOLS);
    for (int k = 0; k < NCOLS; k++) begin
      check("b2b_ready", 32'(o_ready), 32'd1);
      i_data  = 8'(8'h30 + k % 10);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    check("b2b_ready_low", 32'(o_ready), 32'd0);
    check("b2b_busy", 32'(o_busy), 32'd1);
    check("b2b_cursor", 32'(o_cursor_addr), 32'd80);
    wait_idle(200, "b2b_done");
    check("b2b_cursor_end", 32'(o_cursor_addr), 32'd80);
    check("b2b_all_writes", 32'(q.size()), 32'd0);

    // Backspace across a row boundary, CR, ignored control code.
    v = '{8'h08, 1'b0, 12'd0, 8'h00, 12'd79}; apply(v, "bs_row");
    v = '{8'h0D, 1'b0, 12'd0, 8'h00, 12'd0};  apply(v, "cr");
    v = '{8'h07, 1'b0, 12'd0, 8'h00, 12'd0};  apply(v, "bel");

    // LF from row 24 col 5 wraps to row 0 and clears it.
    goto_last_row();
    for (int i = 0; i < 5; i++) begin
      v = '{8'(8'h61 + i), 1'b1, 12'(1920 + i), 8'(8'h61 + i), 12'(1921 + i)};
      apply(v, "row24");
    end
    push_clear(0, NCOLS);
    v = '{8'h0A, 1'b0, 12'd0, 8'h00, 12'd0}; apply(v, "lf_wrap");
    wait_idle(200, "lf_wrap_done");
    v = '{8'h08, 1'b0, 12'd0, 8'h00, 12'd0}; apply(v, "bs_home");
    check("lf_wrap_all_writes", 32'(q.size()), 32'd0);

    // Advance off the last cell wraps to cell 0 and clears row 0.
    goto_last_row();
    for (int i = 0; i < NCOLS; i++) begin
      v = '{8'(8'h41 + i % 26), 1'b1, 12'(1920 + i), 8'(8'h41 + i % 26),
            (i == NCOLS - 1) ? 12'd0 : 12'(1921 + i)};
      apply(v, "adv_wrap");
      if (i == NCOLS - 1) push_clear(0, NCOLS);
    end
    wait_idle(200, "adv_wrap_done");
    check("adv_wrap_cursor", 32'(o_cursor_addr), 32'd0);
    check("adv_wrap_all_writes", 32'(q.size()), 32'd0);

    // Reset during a form-feed clear restarts clearing from address 0.
    wait_idle(10, "abort");
    push_clear(0, NCELLS);
    i_data  = 8'h0C;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (q.size() > NCELLS - 500 && n < 700) begin
        tick();
        n++;
      end
      check("abort_500_writes", 32'(q.size()), 32'(NCELLS - 500));
    end
    i_rst = 1'b1;
    q.delete();
    push_clear(0, NCELLS);
    tick();
    check("abort_rst_we", 32'(o_vram_we), 32'd0);
    check("abort_rst_addr", 32'(o_vram_addr), 32'd0);
    check("abort_rst_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b0;
    wait_idle(2100, "abort_done");
    check("abort_cursor", 32'(o_cursor_addr), 32'd0);
    check("abort_cursor_on", 32'(o_cursor_on), 32'd1);
    check("abort_all_writes", 32'(q.size()), 32'd0);

    repeat (3) tick();
    check("final_queue", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
